trivium_ks_xor: RTL and testbench
=================================

Name: trivium_ks_xor

Overview:
Downstream stage of the Trivium core. Captures one full keystream block from the core's Dout/Dvld output and XORs it, word by word, with a streamed data input to produce ciphertext or plaintext; XOR is symmetric, so one path serves both directions. Requests the next block from the core when the current block is exhausted.

Parameters:
KS_BITS, 4096, keystream block width delivered by the core; must be a multiple of W
W, 32, data word width; N = KS_BITS/W words per block (128 at defaults)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
KsIn  in  KS_BITS  keystream block from core
KsVld  in  1  KsIn valid; sampled only in EMPTY
KsReq  out  1  level request for a new keystream block
DinData  in  W  input data word
DinVld  in  1  input valid
DinRdy  out  1  input ready
DoutData  out  W  DinData XOR keystream word
DoutVld  out  1  output valid
DoutRdy  in  1  downstream ready
Flush  in  1  discard the remainder of the current keystream block
Busy  out  1  block holds unused keystream or has a pending output

Behaviour:
- States: EMPTY (no keystream), READY (buffer holds unused words). Word index idx ranges 0..N-1.
- Reset: state=EMPTY, idx=0, DoutVld=0, DoutData=0. KsReq=0 while RST=1. Busy=0.
- KsReq = (state==EMPTY) && !RST. It is combinational on state.
- EMPTY with KsVld=1: register KsIn into the buffer, idx=0, state=READY on the next edge. KsVld outside EMPTY is ignored; the upstream holds or re-sends only after it sees KsReq.
- Word order is MSB first: word i = KsIn[KS_BITS-1-i*W -: W]. Word 0 is the most significant W bits, matching the core's hex output order.
- DinRdy = (state==READY) && !Flush && (!DoutVld || DoutRdy).
- Accept means DinVld && DinRdy. On accept: DoutData <= DinData ^ word(idx); DoutVld <= 1; idx++. Latency is 1 cycle. Full throughput is one word per cycle under DoutRdy=1.
- Output handshake: DoutVld and DoutData are held stable until DoutRdy. If DoutRdy=1 and there is no accept in that cycle, DoutVld <= 0.
- Wrap: an accept at idx==N-1 sets idx <= 0 and state <= EMPTY. KsReq rises the next cycle, and DinRdy stays 0 until a new block is loaded.
- Flush (single cycle, READY or EMPTY): state <= EMPTY, idx <= 0. Flush has priority over accept in the same cycle. A pending output register is kept and drains normally.
- Flush in EMPTY together with KsVld: the block is not captured.
- Busy = (state==READY) || DoutVld.
- Reset mid-operation drops all buffered keystream and any pending output; nothing is emitted after reset.

Optional Feature:
TRIVIUM_XOR_CNT_EN: adds output WordCnt [31:0]. It counts accepted words and wraps at 2^32. RST clears it; Flush does not. Without the macro the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package trivium_pkg holds the KS_BITS default, the W default, the state enum (EMPTY, READY), and the word-select helper function (MSB-first slice).
- One sub-module, trivium_ks_buf, holds the KS_BITS buffer, idx counter, load/flush logic and word-select output.
- The top holds the handshake and the output register.

Test Plan:
- Load test: reset, then KsVld with word0=32'hDEADBEEF, word1=32'h01234567; feed DinData=0 then 32'hFFFFFFFF with DoutRdy=1. Expect DoutData 32'hDEADBEEF, then 32'hFEDCBA98, each 1 cycle after accept. KsReq=0 while READY.
- Backpressure: DoutRdy=0 for 5 cycles with DinVld=1. Expect DoutVld held, DoutData stable, DinRdy=0, idx frozen; resume with no word lost or duplicated.
- Full block: stream 128 words of DinData=i against an incrementing-pattern block. All outputs match a reference XOR. After word 127, KsReq=1 and DinRdy=0. A second KsVld restarts at word 0.
- Round-trip: XOR of a ciphertext stream with the same block returns the original plaintext.
- Flush: Flush at idx=40 while DinVld=1. Expect no accept that cycle, state EMPTY, KsReq=1. The pending output drains once, and the next block starts at word 0.
- Reset mid-block at idx=10 with DoutVld=1. Next cycle: DoutVld=0, Busy=0, KsReq=1. With TRIVIUM_XOR_CNT_EN, WordCnt=0.

Source files
------------

// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trivium_pkg
// Purpose  : Shared defaults, state encoding and keystream word-slice helper
//            for the Trivium keystream XOR stage.
// Revision : 1.0
// ============================================================================
package trivium_pkg;

  localparam int KS_BITS_DEF = 4096;
  localparam int W_DEF       = 32;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    READY = 1'b1
  } state_e;

  // LSB position of word idx inside a block; word 0 is the most significant
  // slice so the stream follows the core's hex output order.
  function automatic int word_lsb(input int ks_bits, input int w, input int idx);
    return ks_bits - (idx + 1) * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_ks_xor_if.sv
`default_nettype none
// ============================================================================
// Module   : trivium_ks_xor_if
// Purpose  : Keystream, data-in, data-out and control bundle of the
//            keystream XOR stage. master = environment, slave = XOR stage.
// Revision : 1.0
// ============================================================================
interface trivium_ks_xor_if import trivium_pkg::*; #(
  parameter int KS_BITS = KS_BITS_DEF,
  parameter int W       = W_DEF
);

  logic [KS_BITS-1:0] KsIn;
  logic               KsVld;
  logic               KsReq;
  logic [W-1:0]       DinData;
  logic               DinVld;
  logic               DinRdy;
  logic [W-1:0]       DoutData;
  logic               DoutVld;
  logic               DoutRdy;
  logic               Flush;
  logic               Busy;

  modport master (
    output KsIn, KsVld, DinData, DinVld, DoutRdy, Flush,
    input  KsReq, DinRdy, DoutData, DoutVld, Busy
  );

  modport slave (
    input  KsIn, KsVld, DinData, DinVld, DoutRdy, Flush,
    output KsReq, DinRdy, DoutData, DoutVld, Busy
  );

endinterface
`default_nettype wire

// File: rtl/trivium_ks_buf.sv
`default_nettype none
// ============================================================================
// Module   : trivium_ks_buf
// Purpose  : Holds one keystream block, tracks the next unused word and
//            presents it MSB-first. Flush and wrap return to EMPTY.
// Revision : 1.0
// ============================================================================
module trivium_ks_buf import trivium_pkg::*; #(
  parameter  int KS_BITS = KS_BITS_DEF,
  parameter  int W       = W_DEF,
  localparam int N       = KS_BITS / W,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1,
  localparam int LSB_W   = (KS_BITS > 1) ? $clog2(KS_BITS) : 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [KS_BITS-1:0] ks_in_i,
  input  wire logic               ks_vld_i,
  input  wire logic               flush_i,
  input  wire logic               adv_i,
  output state_e                  state_o,
  output logic [W-1:0]            word_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [KS_BITS-1:0] buf_q;
  logic [LSB_W-1:0]   lsb;
  logic               load;

  // A block is taken only while empty and never in a flush cycle.
  assign load = (state_q == EMPTY) && ks_vld_i && !flush_i;

  // State and word index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: flush beats load and advance; last word wraps to EMPTY.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush_i) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (load) begin
      state_d = READY;
      idx_d   = '0;
    end else if (adv_i && (state_q == READY)) begin
      if (idx_q == LAST_IDX) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Keystream storage; contents are meaningless while EMPTY, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_q <= ks_in_i;
    end
  end

  assign lsb     = LSB_W'(word_lsb(KS_BITS, W, int'(idx_q)));
  assign word_o  = buf_q[lsb +: W];
  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/trivium_ks_xor.sv
`default_nettype none
// ============================================================================
// Module   : trivium_ks_xor
// Purpose  : XORs a streamed data word with the next keystream word of the
//            captured block; one registered output stage with valid/ready.
//            Optional macro TRIVIUM_XOR_CNT_EN adds the WordCnt output
//            (accepted-word counter, cleared by RST only).
// Revision : 1.0
// ============================================================================
module trivium_ks_xor import trivium_pkg::*; #(
  parameter int KS_BITS = KS_BITS_DEF,
  parameter int W       = W_DEF
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  trivium_ks_xor_if.slave bus
`ifdef TRIVIUM_XOR_CNT_EN
  ,
  output logic [31:0]     WordCnt
`endif
);

  state_e       state;
  logic [W-1:0] ks_word;
  logic         din_rdy;
  logic         accept;
  logic         dout_vld_q, dout_vld_d;
  logic [W-1:0] dout_data_q, dout_data_d;

  trivium_ks_buf #(
    .KS_BITS (KS_BITS),
    .W       (W)
  ) u_buf (
    .clk      (CLK),
    .rst      (RST),
    .ks_in_i  (bus.KsIn),
    .ks_vld_i (bus.KsVld),
    .flush_i  (bus.Flush),
    .adv_i    (accept),
    .state_o  (state),
    .word_o   (ks_word)
  );

  // Ready only with keystream on hand, no flush, and room in the output stage.
  assign din_rdy = (state == READY) && !bus.Flush && (!dout_vld_q || bus.DoutRdy);
  assign accept  = bus.DinVld && din_rdy;

  // Output stage next value: load on accept, hold until taken, else empty.
  always_comb begin
    dout_vld_d  = dout_vld_q;
    dout_data_d = dout_data_q;
    if (accept) begin
      dout_vld_d  = 1'b1;
      dout_data_d = bus.DinData ^ ks_word;
    end else if (bus.DoutRdy) begin
      dout_vld_d  = 1'b0;
    end
  end

  // Output stage register; reset discards any pending word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_vld_q  <= 1'b0;
      dout_data_q <= '0;
    end else begin
      dout_vld_q  <= dout_vld_d;
      dout_data_q <= dout_data_d;
    end
  end

  assign bus.KsReq    = (state == EMPTY) && !RST;
  assign bus.DinRdy   = din_rdy;
  assign bus.DoutVld  = dout_vld_q;
  assign bus.DoutData = dout_data_q;
  assign bus.Busy     = (state == READY) || dout_vld_q;

`ifdef TRIVIUM_XOR_CNT_EN
  logic [31:0] cnt_q;

  // Accepted-word counter, free-running modulo 2^32; flush leaves it alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign WordCnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trivium_ks_xor.sv
`default_nettype none
// ============================================================================
// Module   : tb_trivium_ks_xor
// Purpose  : Self-checking bench for trivium_ks_xor with a word-queue
//            reference model (words remaining, pending output).
// Revision : 1.0
// ============================================================================
module tb_trivium_ks_xor;
  import trivium_pkg::*;

  localparam int KSB = 4096;
  localparam int W   = 32;
  localparam int N   = KSB / W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trivium_ks_xor_if #(.KS_BITS(KSB), .W(W)) bus ();

`ifdef TRIVIUM_XOR_CNT_EN
  logic [31:0] word_cnt;
`endif

  trivium_ks_xor #(.KS_BITS(KSB), .W(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
`ifdef TRIVIUM_XOR_CNT_EN
    ,
    .WordCnt (word_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: block contents, words left, read position, pending output.
  logic [W-1:0] nb    [N];
  logic [W-1:0] m_blk [N];
  logic [W-1:0] fb    [N];
  logic [W-1:0] cq    [$];
  int           m_left = 0;
  int           m_pos  = 0;
  bit           m_pend = 0;
  bit           m_acc  = 0;
  logic [W-1:0] m_pdata = '0;
  logic [31:0]  m_cnt   = '0;

  function automatic logic [KSB-1:0] pack_blk();
    logic [KSB-1:0] r = '0;
    for (int i = 0; i < N; i++) r = (r << W) | KSB'(nb[i]);
    return r;
  endfunction

  // kind 0 random, 1 incrementing, 2 copy of the saved full block
  task automatic stage(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        1:       nb[i] = {4{8'(i)}};
        2:       nb[i] = fb[i];
        default: nb[i] = $urandom;
      endcase
    end
    bus.KsIn = pack_blk();
  endtask

  function automatic bit exp_rdy();
    return (m_left > 0) && !bus.Flush && (!m_pend || bus.DoutRdy);
  endfunction

  task automatic cyc(input bit vld, input logic [W-1:0] d, input bit rdy,
                     input bit fl, input bit ksv);
    @(negedge clk);
    bus.DinVld  = vld;
    bus.DinData = d;
    bus.DoutRdy = rdy;
    bus.Flush   = fl;
    bus.KsVld   = ksv;
    #1;
  endtask

  // Model update for the coming clock edge, using the inputs now applied.
  task automatic adv();
    logic [W-1:0] w;
    m_acc = bus.DinVld && exp_rdy();
    w = (m_left > 0) ? m_blk[m_pos] : '0;
    if (bus.Flush) begin
      m_left = 0; m_pos = 0;
    end else if (m_left == 0 && bus.KsVld) begin
      m_blk = nb; m_left = N; m_pos = 0;
    end else if (m_acc) begin
      m_left--;
      m_pos = (m_left == 0) ? 0 : m_pos + 1;
    end
    if (m_acc) begin
      m_pend = 1; m_pdata = bus.DinData ^ w; m_cnt++;
    end else if (bus.DoutRdy) begin
      m_pend = 0;
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_pos = 0; m_pend = 0; m_pdata = '0; m_cnt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(0, '0, 1, 0, 0);
    total++; if (bus.KsReq !== 1'b0) begin bad++; $display("FAIL rst_ksreq_during got=%b exp=0", bus.KsReq); end
    cyc(0, '0, 1, 0, 0);
    model_reset();
    @(negedge clk); rst = 1'b0; #1;
    total++; if (bus.DoutVld !== 1'b0) begin bad++; $display("FAIL rst_doutvld got=%b exp=0", bus.DoutVld); end
    total++; if (bus.DoutData !== '0) begin bad++; $display("FAIL rst_doutdata got=%h exp=0", bus.DoutData); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.Busy); end
    total++; if (bus.KsReq !== 1'b1) begin bad++; $display("FAIL rst_ksreq got=%b exp=1", bus.KsReq); end
    total++; if (bus.DinRdy !== 1'b0) begin bad++; $display("FAIL rst_dinrdy got=%b exp=0", bus.DinRdy); end
`ifdef TRIVIUM_XOR_CNT_EN
    total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL rst_wordcnt got=%0d exp=0", word_cnt); end
`endif
    adv();
  endtask

  task automatic test_load();
    stage(0);
    nb[0] = 32'hDEADBEEF;
    nb[1] = 32'h01234567;
    bus.KsIn = pack_blk();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       cyc(0, '0, 1, 0, 1);
        1:       cyc(1, 32'h0, 1, 0, 0);
        2:       cyc(1, 32'hFFFFFFFF, 1, 0, 0);
        default: cyc(0, '0, 1, 0, 0);
      endcase
      total++; if (bus.DinRdy !== exp_rdy()) begin bad++; $display("FAIL load_dinrdy c=%0d got=%b exp=%b", c, bus.DinRdy, exp_rdy()); end
      total++; if (bus.KsReq !== (m_left == 0)) begin bad++; $display("FAIL load_ksreq c=%0d got=%b exp=%b", c, bus.KsReq, m_left == 0); end
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL load_doutvld c=%0d got=%b exp=%b", c, bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL load_doutdata c=%0d got=%h exp=%h", c, bus.DoutData, m_pdata); end
      end
      if (c == 2) begin
        total++; if (bus.DoutData !== 32'hDEADBEEF) begin bad++; $display("FAIL load_word0 got=%h exp=deadbeef", bus.DoutData); end
      end
      if (c == 3) begin
        total++; if (bus.DoutData !== 32'hFEDCBA98) begin bad++; $display("FAIL load_word1 got=%h exp=fedcba98", bus.DoutData); end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 16; c++) begin
      cyc(1, $urandom, !(c >= 4 && c < 9), 0, 0);
      total++; if (bus.DinRdy !== exp_rdy()) begin bad++; $display("FAIL bp_dinrdy c=%0d got=%b exp=%b", c, bus.DinRdy, exp_rdy()); end
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL bp_doutvld c=%0d got=%b exp=%b", c, bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL bp_doutdata c=%0d got=%h exp=%h", c, bus.DoutData, m_pdata); end
      end
      total++; if (bus.Busy !== (m_left > 0 || m_pend)) begin bad++; $display("FAIL bp_busy c=%0d got=%b exp=%b", c, bus.Busy, m_left > 0 || m_pend); end
`ifdef TRIVIUM_XOR_CNT_EN
      total++; if (word_cnt !== m_cnt) begin bad++; $display("FAIL bp_wordcnt c=%0d got=%0d exp=%0d", c, word_cnt, m_cnt); end
`endif
      adv();
    end
  endtask

  task automatic test_flush();
    int guard = 0;
    while (m_pos != 40 && guard < 400) begin
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 2) != 0, 0, 0);
      total++; if (bus.DinRdy !== exp_rdy()) begin bad++; $display("FAIL fl_pre_dinrdy got=%b exp=%b", bus.DinRdy, exp_rdy()); end
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL fl_pre_doutvld got=%b exp=%b", bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL fl_pre_doutdata got=%h exp=%h", bus.DoutData, m_pdata); end
      end
      adv();
      guard++;
    end
    total++; if (m_pos != 40) begin bad++; $display("FAIL fl_reach_idx40 got=%0d exp=40", m_pos); end
    stage(0);
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       cyc(1, $urandom, 1, 1, 0);
        4:       cyc(0, '0, 1, 0, 1);
        default: cyc(1, $urandom, 1, 0, 0);
      endcase
      total++; if (bus.DinRdy !== exp_rdy()) begin bad++; $display("FAIL fl_dinrdy c=%0d got=%b exp=%b", c, bus.DinRdy, exp_rdy()); end
      total++; if (bus.KsReq !== (m_left == 0)) begin bad++; $display("FAIL fl_ksreq c=%0d got=%b exp=%b", c, bus.KsReq, m_left == 0); end
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL fl_doutvld c=%0d got=%b exp=%b", c, bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL fl_doutdata c=%0d got=%h exp=%h", c, bus.DoutData, m_pdata); end
      end
      adv();
    end
  endtask

  task automatic test_full_block();
    cyc(0, '0, 1, 1, 0);
    adv();
    stage(1);
    // Flush together with KsVld in EMPTY must not capture the block.
    cyc(0, '0, 1, 1, 1);
    adv();
    cyc(0, '0, 1, 0, 0);
    total++; if (bus.KsReq !== 1'b1) begin bad++; $display("FAIL fb_flush_ksvld_ksreq got=%b exp=1", bus.KsReq); end
    adv();
    cyc(0, '0, 1, 0, 1);
    adv();
    cq.delete();
    for (int c = 0; c < N + 3; c++) begin
      cyc(1, W'(m_pos), 1, 0, 0);
      total++; if (bus.DinRdy !== exp_rdy()) begin bad++; $display("FAIL fb_dinrdy c=%0d got=%b exp=%b", c, bus.DinRdy, exp_rdy()); end
      total++; if (bus.KsReq !== (m_left == 0)) begin bad++; $display("FAIL fb_ksreq c=%0d got=%b exp=%b", c, bus.KsReq, m_left == 0); end
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL fb_doutvld c=%0d got=%b exp=%b", c, bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL fb_doutdata c=%0d got=%h exp=%h", c, bus.DoutData, m_pdata); end
      end
      if (bus.DoutVld === 1'b1) cq.push_back(bus.DoutData);
      adv();
    end
    total++; if (cq.size() != N) begin bad++; $display("FAIL fb_word_count got=%0d exp=%0d", cq.size(), N); end
    fb = nb;
    stage(0);
    for (int c = 0; c < 4; c++) begin
      cyc(c != 0, $urandom, 1, 0, c == 0);
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL fb_reload_doutvld c=%0d got=%b exp=%b", c, bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL fb_reload_doutdata c=%0d got=%h exp=%h", c, bus.DoutData, m_pdata); end
      end
      adv();
    end
  endtask

  task automatic test_round_trip();
    int p = 0;
    int j = 0;
    int guard = 0;
    cyc(0, '0, 1, 1, 0);
    adv();
    stage(2);
    cyc(0, '0, 1, 0, 1);
    adv();
    while (j < N && guard < 2000) begin
      cyc((p < cq.size()) && (($urandom % 3) != 0), (p < cq.size()) ? cq[p] : '0,
          ($urandom % 4) != 0, 0, 0);
      total++; if (bus.DinRdy !== exp_rdy()) begin bad++; $display("FAIL rt_dinrdy got=%b exp=%b", bus.DinRdy, exp_rdy()); end
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL rt_doutvld got=%b exp=%b", bus.DoutVld, m_pend); end
      if (bus.DoutVld === 1'b1 && bus.DoutRdy === 1'b1) begin
        total++; if (bus.DoutData !== W'(j)) begin bad++; $display("FAIL rt_plaintext j=%0d got=%h exp=%h", j, bus.DoutData, W'(j)); end
        j++;
      end
      adv();
      if (m_acc) p++;
      guard++;
    end
    total++; if (j != N) begin bad++; $display("FAIL rt_timeout got=%0d exp=%0d", j, N); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    stage(0);
    cyc(0, '0, 1, 0, 1);
    adv();
    while (m_pos != 10 && guard < 50) begin
      cyc(1, $urandom, 1, 0, 0);
      total++; if (bus.DoutVld !== m_pend) begin bad++; $display("FAIL rm_doutvld got=%b exp=%b", bus.DoutVld, m_pend); end
      if (m_pend) begin
        total++; if (bus.DoutData !== m_pdata) begin bad++; $display("FAIL rm_doutdata got=%h exp=%h", bus.DoutData, m_pdata); end
      end
      adv();
      guard++;
    end
    total++; if (bus.DoutVld !== 1'b1 || m_pos != 10) begin bad++; $display("FAIL rm_setup got_vld=%b idx=%0d exp_vld=1 idx=10", bus.DoutVld, m_pos); end
    rst = 1'b1;
    cyc(1, $urandom, 0, 0, 0);
    total++; if (bus.KsReq !== 1'b0) begin bad++; $display("FAIL rm_ksreq_during got=%b exp=0", bus.KsReq); end
    model_reset();
    @(negedge clk); rst = 1'b0; #1;
    total++; if (bus.DoutVld !== 1'b0) begin bad++; $display("FAIL rm_doutvld_after got=%b exp=0", bus.DoutVld); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rm_busy_after got=%b exp=0", bus.Busy); end
    total++; if (bus.KsReq !== 1'b1) begin bad++; $display("FAIL rm_ksreq_after got=%b exp=1", bus.KsReq); end
`ifdef TRIVIUM_XOR_CNT_EN
    total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL rm_wordcnt got=%0d exp=0", word_cnt); end
`endif
    adv();
    for (int c = 0; c < 3; c++) begin
      cyc(1, $urandom, 1, 0, 0);
      total++; if (bus.DoutVld !== 1'b0) begin bad++; $display("FAIL rm_no_emit c=%0d got=%b exp=0", c, bus.DoutVld); end
      total++; if (bus.DinRdy !== 1'b0) begin bad++; $display("FAIL rm_dinrdy c=%0d got=%b exp=0", c, bus.DinRdy); end
      adv();
    end
  endtask

  initial begin
    bus.KsIn    = '0;
    bus.KsVld   = 1'b0;
    bus.DinData = '0;
    bus.DinVld  = 1'b0;
    bus.DoutRdy = 1'b1;
    bus.Flush   = 1'b0;
    test_reset();
    test_load();
    test_backpressure();
    test_flush();
    test_full_block();
    test_round_trip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
